// File: rtl/ws281x_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : ws281x_frame_sched
// Brief    : Streams N pixel words from RAM, MSB first, one bit per
//            timing-generator handshake, then holds a latch gap.
//            Define WS281X_RGBW_EN for 32-bit RGBW pixels (default 24-bit).
// Revision : 1.0
// ============================================================================
module ws281x_frame_sched (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_start_in,
  input  logic [7:0]  pix_cnt_in,
  input  logic [15:0] rst_cnt_in,
  output logic        ram_rd_en_out,
  output logic [7:0]  ram_rd_addr_out,
`ifdef WS281X_RGBW_EN
  input  logic [31:0] ram_rd_data_in,
`else
  input  logic [23:0] ram_rd_data_in,
`endif
  output logic        bit_rdy_out,
  output logic        bit_data_out,
  input  logic        bit_done_in,
  output logic        busy_out,
  output logic        frame_done_out
);

`ifdef WS281X_RGBW_EN
  localparam int PW = 32;
`else
  localparam int PW = 24;
`endif
  localparam int CW = $clog2(PW);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_LATCH = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [7:0]    npix_q, npix_d;
  logic [7:0]    idx_q, idx_d;
  logic [15:0]   gap_q, gap_d;
  logic [15:0]   lcnt_q, lcnt_d;
  logic [PW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic          bit_q, bit_d;
  logic          start_ok;
  logic          last_pix;

  assign start_ok = frame_start_in && (pix_cnt_in != 8'd0);
  // Widened so that idx+1 cannot wrap when N = 255.
  assign last_pix = ({1'b0, idx_q} + 9'd1) >= {1'b0, npix_q};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_READ;
      S_READ:  state_d = S_LOAD;
      S_LOAD:  state_d = S_SEND;
      S_SEND:  state_d = S_WAIT;
      S_WAIT: begin
        if (bit_done_in) begin
          if (bcnt_q != '0)   state_d = S_SEND;
          else if (!last_pix) state_d = S_READ;
          else                state_d = S_LATCH;
        end
      end
      S_LATCH: if (lcnt_q <= 16'd1) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_rd_en_out   = (state_q == S_READ);
    ram_rd_addr_out = idx_q;
    bit_rdy_out     = (state_q == S_SEND);
    bit_data_out    = (state_q == S_SEND) ? shreg_q[PW-1] : bit_q;
    busy_out        = (state_q != S_IDLE);
    frame_done_out  = (state_q == S_DONE);
  end

  always_comb begin
    npix_d  = npix_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    lcnt_d  = lcnt_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    bit_d   = bit_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          npix_d = pix_cnt_in;
          gap_d  = rst_cnt_in;
          idx_d  = 8'd0;
        end
      end
      S_LOAD: begin
        shreg_d = ram_rd_data_in;
        bcnt_d  = CW'(PW - 1);
      end
      // Hold the presented bit so the line value stays put through WAIT.
      S_SEND: bit_d = shreg_q[PW-1];
      S_WAIT: begin
        if (bit_done_in) begin
          if (bcnt_q != '0) begin
            shreg_d = {shreg_q[PW-2:0], 1'b0};
            bcnt_d  = bcnt_q - 1'b1;
          end else if (!last_pix) begin
            idx_d = idx_q + 8'd1;
          end else begin
            lcnt_d = (gap_q == 16'd0) ? 16'd1 : gap_q;
            bit_d  = 1'b0;
          end
        end
      end
      S_LATCH: lcnt_d = lcnt_q - 16'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      npix_q  <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      lcnt_q  <= '0;
      shreg_q <= '0;
      bcnt_q  <= '0;
      bit_q   <= 1'b0;
    end else begin
      npix_q  <= npix_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      lcnt_q  <= lcnt_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      bit_q   <= bit_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ws281x_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws281x_frame_sched
// Brief    : Self-checking bench: expected bit stream, read addresses and
//            handshake spacing are derived from the pixel RAM contents.
// Revision : 1.0
// ============================================================================
module tb_ws281x_frame_sched;
`ifdef WS281X_RGBW_EN
  localparam int PW = 32;
`else
  localparam int PW = 24;
`endif

  logic          clk;
  logic          rst;
  logic          frame_start;
  logic [7:0]    pix_cnt;
  logic [15:0]   rst_cnt;
  logic          ram_en;
  logic [7:0]    ram_addr;
  logic [PW-1:0] ram_data;
  logic          bit_rdy;
  logic          bit_data;
  logic          bit_done;
  logic          busy;
  logic          fdone;
  logic          auto_done;
  logic          inj_done;

  assign bit_done = auto_done | inj_done;

  ws281x_frame_sched u_dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .frame_start_in  (frame_start),
    .pix_cnt_in      (pix_cnt),
    .rst_cnt_in      (rst_cnt),
    .ram_rd_en_out   (ram_en),
    .ram_rd_addr_out (ram_addr),
    .ram_rd_data_in  (ram_data),
    .bit_rdy_out     (bit_rdy),
    .bit_data_out    (bit_data),
    .bit_done_in     (bit_done),
    .busy_out        (busy),
    .frame_done_out  (fdone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [PW-1:0] mem [0:255];
  int  done_dly = 1;
  int  dly_cnt  = 0;

  // Model state
  bit  exp_bits[$];
  int  exp_addr[$];
  bit  frame_active = 1'b0;
  int  exp_latch = 0;
  int  cyc = 0, last_rdy = 0, rdy_cnt = 0, rd_cnt = 0, ones = 0;
  int  max_gap = 0, last_fgap = 0, g = 0;
  int  checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Pixel RAM with one-cycle read latency
  always @(posedge clk) begin
    if (ram_en) ram_data <= mem[ram_addr];
  end

  // Timing generator: answers each bit_rdy pulse done_dly cycles later
  always @(posedge clk) begin
    if (rst) begin
      auto_done <= 1'b0;
      dly_cnt   <= 0;
    end else begin
      auto_done <= 1'b0;
      if (bit_rdy) begin
        if (done_dly <= 1) auto_done <= 1'b1;
        else               dly_cnt   <= done_dly - 1;
      end else if (dly_cnt != 0) begin
        dly_cnt <= dly_cnt - 1;
        if (dly_cnt == 1) auto_done <= 1'b1;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (!frame_active) chk("busy_idle", {63'd0, busy}, 64'd0);
      if (ram_en) begin
        chk("rd_expected", {63'd0, exp_addr.size() != 0}, 64'd1);
        if (exp_addr.size() != 0) chk("rd_addr", {56'd0, ram_addr}, 64'(exp_addr.pop_front()));
        rd_cnt++;
      end
      if (bit_rdy) begin
        chk("rdy_expected", {63'd0, exp_bits.size() != 0}, 64'd1);
        if (exp_bits.size() != 0) chk("bit_data", {63'd0, bit_data}, {63'd0, exp_bits.pop_front()});
        if (bit_data) ones++;
        if (rdy_cnt > 0) begin
          g = cyc - last_rdy;
          chk("bit_gap", 64'(g), 64'((rdy_cnt % PW == 0) ? done_dly + 3 : done_dly + 1));
          if (g > max_gap) max_gap = g;
        end
        rdy_cnt++;
        last_rdy = cyc;
      end else if (frame_active && exp_bits.size() == 0 && rdy_cnt > 0 &&
                   cyc > last_rdy + done_dly) begin
        chk("latch_data", {63'd0, bit_data}, 64'd0);
      end
      if (fdone) begin
        chk("done_expected", {63'd0, frame_active}, 64'd1);
        chk("done_bits_left", 64'(exp_bits.size()), 64'd0);
        chk("done_reads_left", 64'(exp_addr.size()), 64'd0);
        last_fgap = cyc - last_rdy;
        chk("latch_len", 64'(last_fgap), 64'(done_dly + ((exp_latch == 0) ? 1 : exp_latch) + 1));
        frame_active = 1'b0;
      end
    end
  end

  task automatic start_frame(input int n, input int rc, input int d);
    @(negedge clk);
    done_dly  = d;
    exp_latch = rc;
    rdy_cnt = 0; rd_cnt = 0; ones = 0; max_gap = 0;
    exp_bits.delete();
    exp_addr.delete();
    for (int p = 0; p < n; p++) begin
      exp_addr.push_back(p);
      for (int b = PW - 1; b >= 0; b--) exp_bits.push_back(mem[p][b]);
    end
    frame_active = (n != 0);
    frame_start  = 1'b1;
    pix_cnt      = 8'(n);
    rst_cnt      = 16'(rc);
    @(negedge clk);
    frame_start = 1'b0;
    pix_cnt     = 8'hFF;
    rst_cnt     = 16'hFFFF;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    int k;
    k = 0;
    while (frame_active && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("frame_timeout", {63'd0, frame_active}, 64'd0);
    if (frame_active) begin
      frame_active = 1'b0;
      do_reset(2);
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) mem[i] = PW'($urandom);
  endtask

  initial begin
    int k;
    rst = 1'b1; frame_start = 1'b0; pix_cnt = 8'd0; rst_cnt = 16'd0;
    inj_done = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",   {63'd0, busy},    64'd0);
    chk("rst_rd_en",  {63'd0, ram_en},  64'd0);
    chk("rst_rdy",    {63'd0, bit_rdy}, 64'd0);
    chk("rst_data",   {63'd0, bit_data},64'd0);
    chk("rst_fdone",  {63'd0, fdone},   64'd0);
    chk("rst_addr",   {56'd0, ram_addr},64'd0);
    rst = 1'b0;

    // Single pixel, slow handshake
`ifdef WS281X_RGBW_EN
    mem[0] = 32'h80000001;
    start_frame(1, 0, 3);
    wait_frame(400);
    chk("A_rdy_count", 64'(rdy_cnt), 64'd32);
    chk("A_ones",      64'(ones),    64'd2);
    chk("A_latch_gap", 64'(last_fgap), 64'd5);
`else
    mem[0] = 24'hA50F81;
    start_frame(1, 4, 3);
    wait_frame(400);
    chk("A_rdy_count", 64'(rdy_cnt), 64'd24);
    chk("A_ones",      64'(ones),    64'd10);
    chk("A_latch_gap", 64'(last_fgap), 64'd8);
`endif

    // Three pixels, immediate handshake
    fill_random(3);
    start_frame(3, 2, 1);
    wait_frame(600);
    chk("B_reads",     64'(rd_cnt),  64'd3);
    chk("B_rdy_count", 64'(rdy_cnt), 64'(3 * PW));
    chk("B_pix_gap",   64'(max_gap), 64'd4);

    // N = 0 is ignored
    start_frame(0, 5, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("N0_busy",  {63'd0, busy},   64'd0);
      chk("N0_rd_en", {63'd0, ram_en}, 64'd0);
    end

    // Stray frame_start / bit_done mid-frame
    fill_random(2);
    start_frame(2, 3, 3);
    k = 0;
    while (!(ram_en && ram_addr == 8'd1) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("C_second_read_seen", {63'd0, ram_en}, 64'd1);
    inj_done = 1'b1; frame_start = 1'b1; pix_cnt = 8'd1;
    @(posedge clk); #1;
    inj_done = 1'b0; frame_start = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bit_rdy && k < 50);
    inj_done = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b0;
    wait_frame(600);
    chk("C_reads",     64'(rd_cnt),  64'd2);
    chk("C_rdy_count", 64'(rdy_cnt), 64'(2 * PW));

    // Reset during bit 10 of pixel 1
    fill_random(3);
    start_frame(3, 2, 2);
    k = 0;
    for (int c = 0; c < 1000 && k < PW + 11; c++) begin
      @(negedge clk);
      if (bit_rdy) k++;
    end
    chk("D_reached_bit10", 64'(k), 64'(PW + 11));
    rst = 1'b1;
    frame_active = 1'b0;
    exp_bits.delete();
    exp_addr.delete();
    @(negedge clk);
    chk("D_busy",  {63'd0, busy},     64'd0);
    chk("D_rd_en", {63'd0, ram_en},   64'd0);
    chk("D_addr",  {56'd0, ram_addr}, 64'd0);
    chk("D_rdy",   {63'd0, bit_rdy},  64'd0);
    chk("D_data",  {63'd0, bit_data}, 64'd0);
    chk("D_fdone", {63'd0, fdone},    64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    fill_random(2);
    start_frame(2, 1, 1);
    wait_frame(600);
    chk("D_restart_reads", 64'(rd_cnt), 64'd2);

    // Zero latch count gives a single latch cycle
    fill_random(2);
    start_frame(2, 0, 1);
    wait_frame(600);
    chk("E_latch_gap", 64'(last_fgap), 64'd3);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ws281x_frame_sched.md
WS281X_FRAME_SCHED -- requirements
Module: ws281x_frame_sched

Interface
REQ-001 SHALL have port clk_in, input, 1, the single clock; all logic is on the rising edge.
REQ-002 SHALL have port rst_in, input, 1, a synchronous active-high reset.
REQ-003 SHALL have port frame_start_in, input, 1, a one-cycle pulse requesting one frame.
REQ-004 SHALL have port pix_cnt_in, input, 8, the pixel count N (0..255).
REQ-005 SHALL have port rst_cnt_in, input, 16, the latch gap length in clk cycles.
REQ-006 SHALL have port ram_rd_en_out, output, 1, the pixel RAM read strobe.
REQ-007 SHALL have port ram_rd_addr_out, output, 8, the pixel index.
REQ-008 SHALL have port ram_rd_data_in, input, PW, pixel word valid exactly 1 cycle after ram_rd_en_out; PW = 24, or 32 per REQ-031.
REQ-009 SHALL have port bit_rdy_out, output, 1, a one-cycle pulse presenting a bit to the timing generator.
REQ-010 SHALL have port bit_data_out, output, 1, the bit value.
REQ-011 SHALL have port bit_done_in, input, 1, a one-cycle pulse from the timing generator marking the current bit finished.
REQ-012 SHALL have port busy_out, output, 1, high whenever state != IDLE.
REQ-013 SHALL have port frame_done_out, output, 1, a one-cycle pulse at frame end.

Function
REQ-014 SHALL implement states IDLE, READ, LOAD, SEND, WAIT, LATCH, DONE.
REQ-015 IDLE: when frame_start_in=1 and pix_cnt_in!=0, SHALL register pix_cnt_in and rst_cnt_in, clear the pixel index to 0, and go to READ; frame_start_in with pix_cnt_in=0 SHALL be ignored.
REQ-016 READ: SHALL drive ram_rd_en_out=1 for exactly one cycle with ram_rd_addr_out=pixel index, then go to LOAD.
REQ-017 LOAD: SHALL capture ram_rd_data_in into a PW-bit shift register, set bit counter=PW-1, then go to SEND.
REQ-018 SEND: SHALL drive bit_rdy_out=1 for exactly one cycle with bit_data_out=shift register MSB, then go to WAIT.
REQ-019 bit_data_out SHALL stay stable from SEND until the next SEND or LATCH entry.
REQ-020 WAIT on bit_done_in=1: if bit counter != 0, SHALL shift left by 1, decrement the counter, and go to SEND; else if pixel index+1 < N, SHALL increment the index and go to READ; else SHALL load the latch counter and go to LATCH.
REQ-021 Bit order SHALL be MSB first; the pixel word is transmitted as stored, with no colour reordering.
REQ-022 LATCH: SHALL hold bit_rdy_out=0 and bit_data_out=0 for max(rst_cnt_in,1) cycles as registered at start, then go to DONE.
REQ-023 DONE: SHALL pulse frame_done_out=1 for one cycle, then go to IDLE.
REQ-024 frame_start_in outside IDLE SHALL be ignored, with no queuing.
REQ-025 bit_done_in outside WAIT SHALL be ignored.
REQ-026 bit_done_in coincident with bit_rdy_out (SEND) SHALL NOT count toward the presented bit.
REQ-027 Changes to pix_cnt_in or rst_cnt_in mid-frame SHALL have no effect on the current frame.
REQ-028 Minimum per-bit sequence SHALL be SEND, WAIT(1 cycle), SEND, giving a 2-cycle bit_rdy_out spacing.
REQ-029 Pixel boundary overhead SHALL be exactly 2 cycles (READ, LOAD) between the last bit_done_in of a pixel and the next SEND-1.

Reset
REQ-030 While rst_in=1, including mid-frame, the block SHALL enter IDLE on the next edge and drive all outputs to 0. Counters and the shift register SHALL be cleared. No frame_done_out pulse SHALL be issued for an aborted frame.

Configuration
REQ-031 Macro WS281X_RGBW_EN: when defined, PW=32 and 32 bits per pixel are sent (bit counter starts at 31). When undefined, PW=24 and 24 bits per pixel are sent. All other behaviour SHALL be identical.

Verification
REQ-032 Reset then frame_start_in with N=1, rst_cnt_in=4, RAM[0]=24'hA50F81, bit_done_in returned 3 cycles after each bit_rdy_out -> 24 bit_rdy_out pulses with data 1010_0101_0000_1111_1000_0001, then 4 LATCH cycles, then one frame_done_out pulse.
REQ-033 N=3, bit_done_in immediate -> ram_rd_addr_out reads 0,1,2 once each, 72 bit_rdy_out pulses, exactly 2 idle cycles between pixels.
REQ-034 frame_start_in with N=0 -> busy_out stays 0 and ram_rd_en_out stays 0.
REQ-035 frame_start_in pulsed again mid-frame, and bit_done_in pulsed while in READ -> no restart and no extra bit; the bit count stays 24·N.
REQ-036 rst_in asserted during bit 10 of pixel 1 -> next cycle all outputs 0 and busy_out=0; no frame_done_out; a following frame starts at address 0.
REQ-037 With WS281X_RGBW_EN defined and RAM[0]=32'h80000001 -> 32 bit_rdy_out pulses, first and last with data=1, the rest 0; rst_cnt_in=0 gives a 1-cycle LATCH.
